// File: rtl/rlbp_serial_rx.sv
// rlbp_serial_rx: deframes the rlbp_macro serial result stream into DATA_W-bit
// codes, buffers them in a small FIFO and exposes them as a Wishbone slave
// with a level-sensitive data-pending interrupt.
module rlbp_serial_rx #(
    parameter int          DATA_W     = 8,
    parameter int          BIT_CYCLES = 4,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0100
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        serial_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [3:0]  wbs_sel_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        irq_o
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = $clog2(BIT_CYCLES) + 1;
    localparam int BIT_W = $clog2(DATA_W) + 1;

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BIT_CYCLES / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYCLES - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_W - 1);
    localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } rx_state_e;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    rx_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BIT_W-1:0]   bits_q, bits_d;
    logic [DATA_W-1:0]  shreg_q, shreg_d;

    logic [DATA_W-1:0]  mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wptr_q, rptr_q;
    logic [LVL_W-1:0]   lvl_q, lvl_d;

    logic               en_q, irq_en_q, ovf_q, ferr_q;
    logic               ack_q, irq_q;
    logic [31:0]        dat_q;

    // ------------------------------------------------------------------
    // Wishbone decode
    // ------------------------------------------------------------------
    logic        hit, fire, wr_ctrl;
    logic [1:0]  reg_sel;
    logic        empty, full;
    logic        pop, push_ok, ovf_set;
    logic        rx_push, rx_ferr;
    logic [31:0] rdata;

    assign hit     = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    // ack_q blocks a second ack in the cycle after one was given
    assign fire    = wbs_cyc_i & wbs_stb_i & hit & ~ack_q;
    assign reg_sel = wbs_adr_i[3:2];
    assign wr_ctrl = fire & wbs_we_i & wbs_sel_i[0] & (reg_sel == 2'd2);

    assign empty   = (lvl_q == '0);
    assign full    = (lvl_q == LVL_FULL);
    // a read of DATA on an empty FIFO returns 0 and leaves pointers alone
    assign pop     = fire & ~wbs_we_i & (reg_sel == 2'd0) & ~empty;
    // when full, a same-cycle pop frees the slot the push lands in
    assign push_ok = rx_push & (~full | pop);
    assign ovf_set = rx_push & full & ~pop;

    logic unused_bits;
    assign unused_bits = ^{wbs_adr_i[1:0], wbs_dat_i[31:8], wbs_dat_i[5:2], wbs_sel_i[3:1]};

    // Receiver next-state: mid-bit sampling with a per-bit cycle counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        bits_d  = bits_q;
        shreg_d = shreg_q;
        rx_push = 1'b0;
        rx_ferr = 1'b0;
        if (!en_q) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    cnt_d  = '0;
                    bits_d = '0;
                    if (!serial_i) state_d = S_START;
                end
                S_START: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_d   = '0;
                        state_d = serial_i ? S_IDLE : S_DATA;
                    end
                end
                S_DATA: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_d   = '0;
                        shreg_d = {serial_i, shreg_q[DATA_W-1:1]};
                        bits_d  = bits_q + BIT_W'(1);
                        if (bits_q == DATA_LAST) state_d = S_STOP;
                    end
                end
                S_STOP: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_d   = '0;
                        state_d = S_IDLE;
                        rx_push = serial_i;
                        rx_ferr = ~serial_i;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Receiver state registers
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bits_q  <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bits_q  <= bits_d;
            shreg_q <= shreg_d;
        end
    end

    // FIFO level: net change from accepted push and pop
    always_comb begin
        lvl_d = lvl_q;
        if (push_ok && !pop)      lvl_d = lvl_q + LVL_W'(1);
        else if (!push_ok && pop) lvl_d = lvl_q - LVL_W'(1);
    end

    // FIFO storage; contents need no reset since level gates every read
    always_ff @(posedge wb_clk_i) begin
        if (push_ok) mem_q[wptr_q] <= shreg_q;
    end

    // FIFO pointers and level
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            lvl_q  <= '0;
        end else begin
            if (push_ok) wptr_q <= wptr_q + PTR_W'(1);
            if (pop)     rptr_q <= rptr_q + PTR_W'(1);
            lvl_q <= lvl_d;
        end
    end

    // Read-data mux for the addressed register
    always_comb begin
        rdata = '0;
        case (reg_sel)
            2'd0: if (!empty) rdata = 32'(mem_q[rptr_q]);
            2'd1: begin
                rdata[3:0] = 4'(lvl_q);
                rdata[4]   = empty;
                rdata[5]   = full;
                rdata[6]   = ovf_q;
                rdata[7]   = ferr_q;
            end
            2'd2: begin
                rdata[0] = en_q;
                rdata[1] = irq_en_q;
                rdata[6] = ferr_q;
                rdata[7] = ovf_q;
            end
            default: rdata = '0;
        endcase
    end

    // Control and sticky status; a new error event wins over a clear
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            en_q     <= 1'b0;
            irq_en_q <= 1'b0;
            ovf_q    <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                en_q     <= wbs_dat_i[0];
                irq_en_q <= wbs_dat_i[1];
            end
            if (ovf_set)                       ovf_q <= 1'b1;
            else if (wr_ctrl && wbs_dat_i[6])  ovf_q <= 1'b0;
            if (rx_ferr)                       ferr_q <= 1'b1;
            else if (wr_ctrl && wbs_dat_i[7])  ferr_q <= 1'b0;
        end
    end

    // Bus response and interrupt; data is zero whenever ack is low
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            ack_q <= 1'b0;
            dat_q <= '0;
            irq_q <= 1'b0;
        end else begin
            ack_q <= fire;
            dat_q <= (fire && !wbs_we_i) ? rdata : 32'h0;
            irq_q <= irq_en_q & ~empty;
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign irq_o     = irq_q;

endmodule

// File: tb/tb_rlbp_serial_rx.sv
// Bench for rlbp_serial_rx: register table, directed frame corner cases and a
// randomized phase checked against a queue-based model of the receiver.
module tb_rlbp_serial_rx;

    localparam int          DW    = 8;
    localparam int          BC    = 4;
    localparam int          DEPTH = 8;
    localparam logic [31:0] BASE  = 32'h3000_0100;

    logic        clk, rst_n, serial;
    logic        cyc, stb, we;
    logic [31:0] adr, wdat;
    logic [3:0]  sel;
    logic        ack;
    logic [31:0] rdat;
    logic        irq;

    rlbp_serial_rx #(.DATA_W(DW), .BIT_CYCLES(BC), .FIFO_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .serial_i(serial),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
        .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_sel_i(sel),
        .wbs_ack_o(ack), .wbs_dat_o(rdat), .irq_o(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // behavioural model: queue of codes plus flags
    logic [7:0] mq[$];
    bit m_ovf, m_fe, m_en, m_ie;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] m_status();
        int l = mq.size();
        return {24'h0, m_fe, m_ovf, l == DEPTH, l == 0, 4'(l)};
    endfunction

    function automatic logic [31:0] m_ctrl();
        return {24'h0, m_ovf, m_fe, 4'h0, m_ie, m_en};
    endfunction

    function automatic logic [31:0] m_pop();
        if (mq.size() == 0) return 32'h0;
        return 32'(mq.pop_front());
    endfunction

    function automatic void m_frame(input logic [7:0] d, input bit stop);
        if (!m_en) return;
        if (!stop) m_fe = 1'b1;
        else if (mq.size() == DEPTH) m_ovf = 1'b1;
        else mq.push_back(d);
    endfunction

    function automatic void m_wctrl(input logic [31:0] d);
        m_en = d[0];
        m_ie = d[1];
        if (d[6]) m_ovf = 1'b0;
        if (d[7]) m_fe = 1'b0;
    endfunction

    function automatic void m_reset();
        mq.delete();
        m_ovf = 0; m_fe = 0; m_en = 0; m_ie = 0;
    endfunction

    // one Wishbone cycle, bounded wait for ack
    task automatic wb(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      output bit acked, output logic [31:0] r);
        @(negedge clk);
        cyc = 1; stb = 1; we = w; adr = a; wdat = d; sel = s;
        acked = 0; r = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (ack) begin
                acked = 1; r = rdat;
                break;
            end
        end
        cyc = 0; stb = 0; we = 0;
    endtask

    task automatic rd(input string nm, input logic [3:0] off, output logic [31:0] r);
        bit a;
        wb(1'b0, BASE + 32'(off), 32'h0, 4'hF, a, r);
        if (!a) begin
            checks++; errors++;
            $display("FAIL %s ack timeout got 0 exp 1", nm);
        end
    endtask

    task automatic wr(input logic [3:0] off, input logic [31:0] d);
        bit a;
        logic [31:0] r;
        wb(1'b1, BASE + 32'(off), d, 4'hF, a, r);
        if (!a) begin
            checks++; errors++;
            $display("FAIL write ack timeout off %h", off);
        end
    endtask

    // drive one frame starting at the next falling clock edge
    task automatic send_frame(input logic [7:0] d, input bit stop);
        @(negedge clk);
        serial = 0;
        repeat (BC) @(negedge clk);
        for (int i = 0; i < DW; i++) begin
            serial = d[i];
            repeat (BC) @(negedge clk);
        end
        serial = stop;
        repeat (BC) @(negedge clk);
        serial = 1;
        repeat (BC) @(negedge clk);
    endtask

    typedef struct {
        string       nm;
        bit          w;
        logic [3:0]  off;
        logic [31:0] d;
        logic [3:0]  s;
        bit          oob;
        bit          exp_ack;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vt[14];
    logic [31:0] r, e;
    bit a;
    logic [7:0] b;

    initial begin
        vt[0]  = '{"rst_status",   0, 4'h4, 32'h0,  4'hF, 0, 1, 32'h10};
        vt[1]  = '{"rst_ctrl",     0, 4'h8, 32'h0,  4'hF, 0, 1, 32'h0};
        vt[2]  = '{"empty_data",   0, 4'h0, 32'h0,  4'hF, 0, 1, 32'h0};
        vt[3]  = '{"rsvd_rd",      0, 4'hC, 32'h0,  4'hF, 0, 1, 32'h0};
        vt[4]  = '{"wr_nosel",     1, 4'h8, 32'h3,  4'hE, 0, 1, 32'h0};
        vt[5]  = '{"ctrl_nosel",   0, 4'h8, 32'h0,  4'hF, 0, 1, 32'h0};
        vt[6]  = '{"wr_ctrl",      1, 4'h8, 32'h3,  4'h1, 0, 1, 32'h0};
        vt[7]  = '{"ctrl_rb",      0, 4'h8, 32'h0,  4'hF, 0, 1, 32'h3};
        vt[8]  = '{"rsvd_wr",      1, 4'hC, 32'hFF, 4'hF, 0, 1, 32'h0};
        vt[9]  = '{"ctrl_rb2",     0, 4'h8, 32'h0,  4'hF, 0, 1, 32'h3};
        vt[10] = '{"oob_rd",       0, 4'h0, 32'h0,  4'hF, 1, 0, 32'h0};
        vt[11] = '{"oob_wr",       1, 4'h8, 32'h0,  4'hF, 1, 0, 32'h0};
        vt[12] = '{"ctrl_rb3",     0, 4'h8, 32'h0,  4'hF, 0, 1, 32'h3};
        vt[13] = '{"status_rb",    0, 4'h4, 32'h0,  4'hF, 0, 1, 32'h10};

        rst_n = 0; serial = 1; cyc = 0; stb = 0; we = 0; adr = 0; wdat = 0; sel = 0;
        m_reset();
        repeat (3) @(negedge clk);
        chk("rst_ack", 32'(ack), 32'h0);
        chk("rst_dat", rdat, 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        rst_n = 1;

        // register table
        foreach (vt[i]) begin
            wb(vt[i].w, BASE + (vt[i].oob ? 32'h10 : 32'h0) + 32'(vt[i].off), vt[i].d, vt[i].s, a, r);
            chk({vt[i].nm, "_ack"}, 32'(a), 32'(vt[i].exp_ack));
            if (vt[i].exp_ack) chk(vt[i].nm, r, vt[i].exp_rd);
        end
        m_en = 1; m_ie = 1;

        // single frame with exact receive latency
        fork
            send_frame(8'hA5, 1);
            begin
                repeat (38) @(negedge clk);
                rd("lat38", 4'h4, r);
                chk("lat38_status", r, 32'h10);
                chk("lat38_irq", 32'(irq), 32'h0);
                rd("lat39", 4'h4, r);
                chk("lat39_status", r, 32'h01);
                chk("lat39_irq", 32'(irq), 32'h1);
            end
        join
        m_frame(8'hA5, 1);
        rd("single", 4'h0, r);
        chk("single_data", r, m_pop());
        repeat (2) @(negedge clk);
        chk("single_irq_fall", 32'(irq), 32'h0);
        rd("single_st", 4'h4, r);
        chk("single_status", r, m_status());

        // one-cycle low glitch, then a clean frame
        @(negedge clk); serial = 0;
        @(negedge clk); serial = 1;
        repeat (10) @(negedge clk);
        rd("glitch", 4'h4, r);
        chk("glitch_status", r, m_status());
        send_frame(8'h5A, 1); m_frame(8'h5A, 1);
        rd("post_glitch", 4'h0, r);
        chk("post_glitch_data", r, m_pop());

        // framing error and its clear
        send_frame(8'h3C, 0); m_frame(8'h3C, 0);
        rd("ferr", 4'h4, r);
        chk("ferr_status", r, m_status());
        rd("ferr_c", 4'h8, r);
        chk("ferr_ctrl", r, m_ctrl());
        wr(4'h8, 32'h83); m_wctrl(32'h83);
        rd("ferr_clr", 4'h4, r);
        chk("ferr_clr_status", r, m_status());

        // overflow with nine frames
        for (int i = 1; i <= 9; i++) begin
            send_frame(8'(i), 1); m_frame(8'(i), 1);
        end
        rd("ovf", 4'h4, r);
        chk("ovf_status", r, m_status());
        for (int i = 0; i < 9; i++) begin
            rd("ovf_drain", 4'h0, r);
            chk($sformatf("ovf_drain%0d", i), r, m_pop());
        end
        wr(4'h8, 32'h43); m_wctrl(32'h43);
        rd("ovf_clr", 4'h4, r);
        chk("ovf_clr_status", r, m_status());

        // push and pop on the same edge while full
        for (int i = 0; i < DEPTH; i++) begin
            b = 8'($urandom);
            send_frame(b, 1); m_frame(b, 1);
        end
        e = m_pop();
        fork
            send_frame(8'h77, 1);
            begin
                repeat (38) @(negedge clk);
                rd("simul", 4'h0, r);
                chk("simul_data", r, e);
            end
        join
        m_frame(8'h77, 1);
        rd("simul_st", 4'h4, r);
        chk("simul_status", r, m_status());
        for (int i = 0; i < DEPTH; i++) begin
            rd("simul_drain", 4'h0, r);
            chk($sformatf("simul_drain%0d", i), r, m_pop());
        end

        // disable mid-frame, then re-enable
        fork
            send_frame(8'h99, 1);
            begin
                repeat (15) @(negedge clk);
                wr(4'h8, 32'h2);
            end
        join
        m_wctrl(32'h2);
        rd("dis", 4'h4, r);
        chk("dis_status", r, m_status());
        wr(4'h8, 32'h3); m_wctrl(32'h3);
        send_frame(8'h66, 1); m_frame(8'h66, 1);
        rd("reen", 4'h0, r);
        chk("reen_data", r, m_pop());

        // reset at data bit 4 with data pending
        send_frame(8'h11, 1); m_frame(8'h11, 1);
        repeat (2) @(negedge clk);
        chk("pre_rst_irq", 32'(irq), 32'h1);
        fork
            send_frame(8'h22, 1);
            begin
                repeat (21) @(negedge clk);
                rst_n = 0;
                #1;
                chk("mid_rst_ack", 32'(ack), 32'h0);
                chk("mid_rst_dat", rdat, 32'h0);
                chk("mid_rst_irq", 32'(irq), 32'h0);
                repeat (3) @(negedge clk);
                rst_n = 1;
            end
        join
        m_reset();
        rd("post_rst", 4'h4, r);
        chk("post_rst_status", r, m_status());
        rd("post_rst_c", 4'h8, r);
        chk("post_rst_ctrl", r, m_ctrl());

        // interrupt gated by irq_en
        wr(4'h8, 32'h1); m_wctrl(32'h1);
        send_frame(8'h42, 1); m_frame(8'h42, 1);
        chk("irq_gated", 32'(irq), 32'h0);
        wr(4'h8, 32'h3); m_wctrl(32'h3);
        repeat (2) @(negedge clk);
        chk("irq_enabled", 32'(irq), 32'h1);

        // randomized operations against the model
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: begin
                    bit st;
                    b  = 8'($urandom);
                    st = ($urandom_range(0, 7) != 0);
                    send_frame(b, st); m_frame(b, st);
                end
                5, 6: begin
                    rd("rnd_data", 4'h0, r);
                    chk($sformatf("rnd_data%0d", n), r, m_pop());
                end
                7: begin
                    rd("rnd_st", 4'h4, r);
                    chk($sformatf("rnd_status%0d", n), r, m_status());
                end
                8: begin
                    e = 32'($urandom) & 32'hC2;
                    e[0] = ($urandom_range(0, 3) != 0);
                    wr(4'h8, e); m_wctrl(e);
                end
                default: begin
                    rd("rnd_c", 4'h8, r);
                    chk($sformatf("rnd_ctrl%0d", n), r, m_ctrl());
                end
            endcase
            repeat (2) @(negedge clk);
            chk($sformatf("rnd_irq%0d", n), 32'(irq), 32'(m_ie && mq.size() != 0));
        end
        rd("final_st", 4'h4, r);
        chk("final_status", r, m_status());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout got running exp finished");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
